rvfi_bus_dmem_write_check: RTL and testbench

Formal checker for external data-bus writes, the write-side counterpart of the bus data-read check. It tracks one symbolic XLEN-wide memory word. Every store the core retires to that word must later appear on the checked bus, byte-exact and in program order, with no unsolicited bus writes to the word. It sits beside the core in the formal harness and only observes RVFI and RVFI_BUS signals.

---
 rtl/rvfi_bus_dmem_write_check_if.sv | 45 ++++
 rtl/rvfi_bus_dmem_write_check.sv | 185 ++++++++++++++++++
 tb/tb_rvfi_bus_dmem_write_check.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rvfi_bus_dmem_write_check_if.sv
// Signal bundle for the bus data-write checker: retirement channels,
// bus channels, the tracked word address and the checker's verdict flags.
interface rvfi_bus_dmem_write_check_if #(
  parameter int NRET = 1,
  parameter int NBUS = 1,
  parameter int XLEN = 32
);
  // tracked word; tie to a rand-const register in the formal harness
  logic [XLEN-1:0]          dmem_addr;

  logic [NRET-1:0]          rvfi_valid;
  logic [NRET*XLEN-1:0]     rvfi_mem_addr;
  logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask;
  logic [NRET*XLEN-1:0]     rvfi_mem_wdata;

  logic [NBUS-1:0]          rvfi_bus_valid;
  logic [NBUS-1:0]          rvfi_bus_data;
  logic [NBUS*XLEN-1:0]     rvfi_bus_addr;
  logic [NBUS*XLEN/8-1:0]   rvfi_bus_rmask;
  logic [NBUS*XLEN/8-1:0]   rvfi_bus_wmask;
  logic [NBUS*XLEN-1:0]     rvfi_bus_wdata;
  logic [NBUS-1:0]          rvfi_bus_fault;

  // registered verdicts for the previous cycle's traffic
  logic                     fail_unsol;
  logic                     fail_cover;
  logic                     fail_data;
  logic                     fail_timeout;
  logic                     assume_viol;
  logic [7:0]               fifo_count;

  modport master (
    output dmem_addr, rvfi_valid, rvfi_mem_addr, rvfi_mem_wmask, rvfi_mem_wdata,
           rvfi_bus_valid, rvfi_bus_data, rvfi_bus_addr, rvfi_bus_rmask,
           rvfi_bus_wmask, rvfi_bus_wdata, rvfi_bus_fault,
    input  fail_unsol, fail_cover, fail_data, fail_timeout, assume_viol, fifo_count
  );

  modport slave (
    input  dmem_addr, rvfi_valid, rvfi_mem_addr, rvfi_mem_wmask, rvfi_mem_wdata,
           rvfi_bus_valid, rvfi_bus_data, rvfi_bus_addr, rvfi_bus_rmask,
           rvfi_bus_wmask, rvfi_bus_wdata, rvfi_bus_fault,
    output fail_unsol, fail_cover, fail_data, fail_timeout, assume_viol, fifo_count
  );
endinterface

// File: rtl/rvfi_bus_dmem_write_check.sv
// Bus data-write checker: every store retired to the tracked word must
// reach the bus byte-exact and in program order, with no unsolicited writes.
// Optional macro RISCV_FORMAL_BUS_WRITE_TIMEOUT_EN adds a bounded-liveness
// age check on the oldest pending store. Under FORMAL the verdicts also drive
// immediate assert/assume statements.
module rvfi_bus_dmem_write_check #(
  parameter int NRET    = 1,
  parameter int NBUS    = 1,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input logic clock,
  input logic reset,
  input logic check,
  rvfi_bus_dmem_write_check_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // every address is considered reachable in this harness
  function automatic logic addr_valid(input logic [XLEN-1:0] a);
    return a == a;
  endfunction

  logic [NB-1:0]   mask_q [DEPTH];
  logic [NB-1:0]   mask_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [NB-1:0]   head_mask_q, head_mask_d;
  logic            popped;
  logic            unsol, cover_err, data_err, asm_full, asm_fault, timeout_err;
  logic            fail_unsol_q, fail_unsol_d, fail_cover_q, fail_cover_d;
  logic            fail_data_q, fail_data_d, fail_timeout_q, fail_timeout_d;
  logic            assume_viol_q, assume_viol_d;

  // push retired stores, then drain bus writes against the FIFO head in channel order
  always_comb begin
    logic [XLEN-1:0] a;
    logic [NB-1:0]   m;
    mask_d      = mask_q;
    data_d      = data_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    head_mask_d = head_mask_q;
    popped      = 1'b0;
    unsol       = 1'b0;
    cover_err   = 1'b0;
    data_err    = 1'b0;
    asm_full    = 1'b0;
    asm_fault   = 1'b0;
    for (int c = 0; c < NRET; c++) begin
      a = bus.rvfi_mem_addr[c*XLEN +: XLEN];
      m = bus.rvfi_mem_wmask[c*NB +: NB];
      if (bus.rvfi_valid[c] && a == bus.dmem_addr && addr_valid(bus.dmem_addr) && m != '0) begin
        if (count_d == FULL) begin
          asm_full = 1'b1;
        end else begin
          mask_d[wptr_d] = m;
          data_d[wptr_d] = bus.rvfi_mem_wdata[c*XLEN +: XLEN];
          if (count_d == '0) head_mask_d = m;
          wptr_d  = wptr_d + PW'(1);
          count_d = count_d + CW'(1);
        end
      end
    end
    for (int c = 0; c < NBUS; c++) begin
      if (bus.rvfi_bus_valid[c] && bus.rvfi_bus_data[c]) begin
        a = bus.rvfi_bus_addr[c*XLEN +: XLEN];
        for (int i = 0; i < NB; i++) begin
          for (int j = 0; j < NB; j++) begin
            if (a + XLEN'(i) == bus.dmem_addr + XLEN'(j)) begin
              if (bus.rvfi_bus_fault[c] &&
                  (bus.rvfi_bus_rmask[c*NB+i] || bus.rvfi_bus_wmask[c*NB+i]))
                asm_fault = 1'b1;
              if (bus.rvfi_bus_wmask[c*NB+i]) begin
                if (count_d == '0) begin
                  unsol = 1'b1;
                end else if (!head_mask_d[j]) begin
                  cover_err = 1'b1;
                end else begin
                  if (bus.rvfi_bus_wdata[c*XLEN + i*8 +: 8] != data_d[rptr_d][j*8 +: 8])
                    data_err = 1'b1;
                  head_mask_d[j] = 1'b0;
                end
              end
            end
          end
        end
        if (count_d != '0 && head_mask_d == '0) begin
          rptr_d      = rptr_d + PW'(1);
          count_d     = count_d - CW'(1);
          popped      = 1'b1;
          head_mask_d = (count_d != '0) ? mask_d[rptr_d] : '0;
        end
      end
    end
  end

`ifdef RISCV_FORMAL_BUS_WRITE_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT + 1);
  logic [AW-1:0] age_q, age_d;

  // age the oldest pending store; restart on every pop or when empty
  always_comb begin
    age_d = age_q;
    if (popped || count_d == '0)
      age_d = '0;
    else if (count_q != '0 && age_q != AW'(TIMEOUT))
      age_d = age_q + AW'(1);
    timeout_err = (age_d >= AW'(TIMEOUT));
  end

  // age counter register
  always_ff @(posedge clock) begin
    if (reset) age_q <= '0;
    else       age_q <= age_d;
  end
`else
  // no liveness tracking in this build
  always_comb timeout_err = 1'b0;
`endif

  // verdicts are suppressed while reset is held; assumption hits ignore check
  always_comb begin
    fail_unsol_d   = !reset && check && unsol;
    fail_cover_d   = !reset && check && cover_err;
    fail_data_d    = !reset && check && data_err;
    fail_timeout_d = !reset && check && timeout_err;
    assume_viol_d  = !reset && (asm_full || asm_fault);
  end

  // control state and verdict registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      head_mask_q    <= '0;
      fail_unsol_q   <= 1'b0;
      fail_cover_q   <= 1'b0;
      fail_data_q    <= 1'b0;
      fail_timeout_q <= 1'b0;
      assume_viol_q  <= 1'b0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      head_mask_q    <= head_mask_d;
      fail_unsol_q   <= fail_unsol_d;
      fail_cover_q   <= fail_cover_d;
      fail_data_q    <= fail_data_d;
      fail_timeout_q <= fail_timeout_d;
      assume_viol_q  <= assume_viol_d;
    end
  end

  // FIFO payload storage, meaningful only under the valid pointers
  always_ff @(posedge clock) begin
    mask_q <= mask_d;
    data_q <= data_d;
  end

`ifdef FORMAL
  // formal view of the same verdicts
  always_comb begin
    if (!reset) begin
      assume (!asm_full && !asm_fault);
      assert (!check || !(unsol || cover_err || data_err || timeout_err));
    end
  end
`endif

  assign bus.fail_unsol   = fail_unsol_q;
  assign bus.fail_cover   = fail_cover_q;
  assign bus.fail_data    = fail_data_q;
  assign bus.fail_timeout = fail_timeout_q;
  assign bus.assume_viol  = assume_viol_q;
  assign bus.fifo_count   = 8'(count_q);
endmodule

// File: tb/tb_rvfi_bus_dmem_write_check.sv
// Directed bench for rvfi_bus_dmem_write_check: one retire and one bus channel,
// tracked word at 0x100. Verdict flags are registered, so each vector's
// verdict is read #1 after the edge that consumes it.
module tb_rvfi_bus_dmem_write_check;
`ifdef RISCV_FORMAL_BUS_WRITE_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic clk = 1'b0;
  logic reset;
  logic check;
  int   n_checks = 0;
  int   n_fail   = 0;

  rvfi_bus_dmem_write_check_if #(.NRET(1), .NBUS(1), .XLEN(32)) bif ();

  rvfi_bus_dmem_write_check #(.NRET(1), .NBUS(1), .XLEN(32), .DEPTH(4), .TIMEOUT(TO)) dut (
    .clock (clk),
    .reset (reset),
    .check (check),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // one cycle of stimulus on both channels, then settle past the edge
  task automatic cyc(input logic rv, input logic [31:0] ra, input logic [3:0] rm,
                     input logic [31:0] rd, input logic bv, input logic [31:0] ba,
                     input logic [3:0] brm, input logic [3:0] bwm,
                     input logic [31:0] bd, input logic bf);
    bif.rvfi_valid     = rv;
    bif.rvfi_mem_addr  = ra;
    bif.rvfi_mem_wmask = rm;
    bif.rvfi_mem_wdata = rd;
    bif.rvfi_bus_valid = bv;
    bif.rvfi_bus_data  = bv;
    bif.rvfi_bus_addr  = ba;
    bif.rvfi_bus_rmask = brm;
    bif.rvfi_bus_wmask = bwm;
    bif.rvfi_bus_wdata = bd;
    bif.rvfi_bus_fault = bf;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 4'h0, 32'h0, 0);
  endtask

  task automatic retire(input logic [31:0] ra, input logic [3:0] rm, input logic [31:0] rd);
    cyc(1, ra, rm, rd, 0, 32'h0, 4'h0, 4'h0, 32'h0, 0);
  endtask

  task automatic bwrite(input logic [31:0] ba, input logic [3:0] bwm, input logic [31:0] bd);
    cyc(0, 32'h0, 4'h0, 32'h0, 1, ba, 4'h0, bwm, bd, 0);
  endtask

  task automatic expect_state(input string tag, input logic u, input logic cv,
                              input logic d, input logic av, input int cnt);
    expect_eq({tag, ".unsol"}, 32'(bif.fail_unsol), 32'(u));
    expect_eq({tag, ".cover"}, 32'(bif.fail_cover), 32'(cv));
    expect_eq({tag, ".data"},  32'(bif.fail_data),  32'(d));
    expect_eq({tag, ".assume"}, 32'(bif.assume_viol), 32'(av));
    expect_eq({tag, ".count"}, 32'(bif.fifo_count), 32'(cnt));
  endtask

  initial begin
    bif.dmem_addr = 32'h0000_0100;
    check = 1'b1;
    reset = 1'b1;
    idle();
    idle();
    expect_state("reset", 0, 0, 0, 0, 0);
    expect_eq("reset.timeout", 32'(bif.fail_timeout), 32'd0);
    reset = 1'b0;

    // full-word store drained two cycles later
    retire(32'h100, 4'hF, 32'hDEADBEEF);
    expect_state("sw_push", 0, 0, 0, 0, 1);
    idle();
    bwrite(32'h100, 4'hF, 32'hDEADBEEF);
    expect_state("sw_drain", 0, 0, 0, 0, 0);

    // byte store, bus carries the wrong byte value
    retire(32'h100, 4'b0010, 32'h0000_5A00);
    bwrite(32'h100, 4'b0010, 32'h0000_5B00);
    expect_state("sb_bad", 0, 0, 1, 0, 0);

    // bus write with nothing pending
    bwrite(32'h100, 4'hF, 32'h1234_5678);
    expect_state("unsol", 1, 0, 0, 0, 0);

    // same unsolicited write with checking disabled
    check = 1'b0;
    bwrite(32'h100, 4'hF, 32'h1234_5678);
    expect_state("unsol_nochk", 0, 0, 0, 0, 0);
    check = 1'b1;

    // two stores drained out of order; second bus write then matches the new head
    retire(32'h100, 4'hF, 32'h1111_1111);
    retire(32'h100, 4'hF, 32'h2222_2222);
    expect_state("ab_push", 0, 0, 0, 0, 2);
    bwrite(32'h100, 4'hF, 32'h2222_2222);
    expect_state("ab_order", 0, 0, 1, 0, 1);
    bwrite(32'h100, 4'hF, 32'h2222_2222);
    expect_state("ab_second", 0, 0, 0, 0, 0);

    // retire and bus write in the same cycle
    cyc(1, 32'h100, 4'hF, 32'hCAFEF00D, 1, 32'h100, 4'h0, 4'hF, 32'hCAFEF00D, 0);
    expect_state("same_cyc", 0, 0, 0, 0, 0);

    // halfword reaching the word through an unaligned bus beat at 0xFE
    retire(32'h100, 4'b0011, 32'h0000_BEEF);
    bwrite(32'h0FE, 4'b1100, 32'hBEEF_0000);
    expect_state("offset_bus", 0, 0, 0, 0, 0);

    // byte 1 written although the pending store covers only byte 0
    retire(32'h100, 4'b0001, 32'h0000_0077);
    bwrite(32'h100, 4'b0010, 32'h0000_7700);
    expect_state("uncovered", 0, 1, 0, 0, 1);
    bwrite(32'h100, 4'b0001, 32'h0000_0077);
    expect_state("uncov_drain", 0, 0, 0, 0, 0);

    // read-only beats and stores elsewhere are ignored
    cyc(0, 32'h0, 4'h0, 32'h0, 1, 32'h100, 4'hF, 4'h0, 32'h0, 0);
    expect_state("rmask_only", 0, 0, 0, 0, 0);
    retire(32'h200, 4'hF, 32'h5555_5555);
    expect_state("other_addr", 0, 0, 0, 0, 0);

    // fault on a tracked read beat is a trace restriction
    cyc(0, 32'h0, 4'h0, 32'h0, 1, 32'h100, 4'hF, 4'h0, 32'h0, 1);
    expect_state("fault", 0, 0, 0, 1, 0);

    // fill the FIFO, overflow it, then reset mid-operation
    for (int k = 0; k < 4; k++) retire(32'h100, 4'hF, 32'(k + 1));
    expect_state("full", 0, 0, 0, 0, 4);
    retire(32'h100, 4'hF, 32'h0000_0009);
    expect_state("overflow", 0, 0, 0, 1, 4);
    reset = 1'b1;
    bwrite(32'h100, 4'hF, 32'hDEADBEEF);
    expect_state("mid_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    bwrite(32'h100, 4'hF, 32'h0000_0001);
    expect_state("post_reset", 1, 0, 0, 0, 0);

    // oldest store left waiting on the bus
    retire(32'h100, 4'hF, 32'hA5A5_A5A5);
    for (int k = 0; k < 3; k++) idle();
    expect_eq("timeout_early", 32'(bif.fail_timeout), 32'd0);
    idle();
`ifdef RISCV_FORMAL_BUS_WRITE_TIMEOUT_EN
    expect_eq("timeout_hit", 32'(bif.fail_timeout), 32'd1);
`else
    expect_eq("timeout_off", 32'(bif.fail_timeout), 32'd0);
`endif
    bwrite(32'h100, 4'hF, 32'hA5A5_A5A5);
    expect_state("late_drain", 0, 0, 0, 0, 0);
    expect_eq("late_timeout", 32'(bif.fail_timeout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
